// File: rtl/counter_inc_dec_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_inc_dec_arb_if
// Brief    : Requester / counter bundle shared between the inc/dec arbiter
//            and its environment (requesters plus the external counter).
// Revision : 1.0 - initial release
// ============================================================================
interface counter_inc_dec_arb_if #(
    parameter int NREQ = 4,
    parameter int CW   = 8
);
    // Requester side
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] op;
    logic [NREQ-1:0] gnt;

    // External counter side
    logic            inc;
    logic            dec;
    logic [CW-1:0]   cnt;

    // Shadow and status
    logic [CW-1:0]   exp_cnt;
    logic            at_max;
    logic            at_min;
    logic            err;
    logic            err_sticky;

    // Environment view: requesters and the counter drive req/op/cnt
    modport master (
        output req, op, cnt,
        input  gnt, inc, dec, exp_cnt, at_max, at_min, err, err_sticky
    );

    // Arbiter view
    modport slave (
        input  req, op, cnt,
        output gnt, inc, dec, exp_cnt, at_max, at_min, err, err_sticky
    );
endinterface
`default_nettype wire

// File: rtl/counter_inc_dec_arb.sv
`default_nettype none
// ============================================================================
// Module   : counter_inc_dec_arb
// Brief    : Round-robin arbiter sharing one external up/down counter between
//            NREQ requesters. Grants one inc or dec per cycle, never past
//            MAX/MIN, and keeps a shadow of the expected count that is
//            re-aligned (with an error pulse) when the counter diverges.
// Revision : 1.0 - initial release
// ============================================================================
module counter_inc_dec_arb #(
    parameter int NREQ = 4,   // must match the interface instance
    parameter int CW   = 8,   // must match the interface instance
    parameter int MAX  = 255,
    parameter int MIN  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    counter_inc_dec_arb_if.slave  bus
);

    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CW-1:0] c_MAX_CNT = CW'(MAX);
    localparam logic [CW-1:0] c_MIN_CNT = CW'(MIN);
    localparam logic [NREQ-1:0] c_ONE_HOT0 = NREQ'(1);
    localparam logic [RW-1:0] c_LAST_IDX = RW'(NREQ - 1);
    localparam logic [RW:0]   c_NREQ_W   = (RW + 1)'(NREQ);

    // State encoding
    localparam logic [1:0] c_ST_SYNC   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_RESYNC = 2'd2;

    // Registered state and outputs
    logic [1:0]      r_state;
    logic [RW-1:0]   r_rr;
    logic [NREQ-1:0] r_gnt;
    logic            r_inc;
    logic            r_dec;
    logic [CW-1:0]   r_exp_cnt;
    logic            r_err;
    logic            r_err_sticky;

    // Combinational helpers
    logic [CW-1:0]   w_proj;
    logic            w_proj_max;
    logic            w_proj_min;
    logic [NREQ-1:0] w_elig;
    logic            w_found;
    logic [RW-1:0]   w_win;
    logic [RW:0]     w_sum;
    logic [RW-1:0]   w_rr_next;
    logic            w_mismatch;

    // Count as it will be once the op already on inc/dec lands in the counter
    assign w_proj     = r_exp_cnt + CW'(r_inc) - CW'(r_dec);
    assign w_proj_max = (w_proj == c_MAX_CNT);
    assign w_proj_min = (w_proj == c_MIN_CNT);
    assign w_mismatch = (bus.cnt != r_exp_cnt);

    // A requester may go only if its op keeps the count inside [MIN, MAX];
    // the one granted this cycle sits out so a still-held req is not served
    // twice for a single request.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
        assign w_elig[gi] = bus.req[gi] && !r_gnt[gi] &&
                            (bus.op[gi] ? !w_proj_min : !w_proj_max);
    end

    // Round-robin search starting at the pointer, wrapping modulo NREQ
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int j = 0; j < NREQ; j++) begin
            w_sum = {1'b0, r_rr} + (RW + 1)'(j);
            if (w_sum >= c_NREQ_W) begin
                w_sum = w_sum - c_NREQ_W;
            end
            if (!w_found && w_elig[w_sum[RW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[RW-1:0];
            end
        end
    end

    assign w_rr_next = (w_win == c_LAST_IDX) ? '0 : w_win + RW'(1);

    // Control FSM, arbitration, shadow tracking and mismatch recovery
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_SYNC;
            r_rr         <= '0;
            r_gnt        <= '0;
            r_inc        <= 1'b0;
            r_dec        <= 1'b0;
            r_exp_cnt    <= '0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            // Grants and the error flag are single-cycle pulses by default
            r_gnt     <= '0;
            r_inc     <= 1'b0;
            r_dec     <= 1'b0;
            r_err     <= 1'b0;
            r_exp_cnt <= w_proj;

            case (r_state)
                c_ST_SYNC: begin
                    // Counter is coming out of reset; give it one quiet cycle
                    r_state <= c_ST_RUN;
                end

                default: begin
                    if (w_mismatch) begin
                        // Trust the counter, then add back whatever op it
                        // is absorbing on this same edge.
                        r_err        <= 1'b1;
                        r_err_sticky <= 1'b1;
                        r_exp_cnt    <= bus.cnt + CW'(r_inc) - CW'(r_dec);
                        r_state      <= c_ST_RESYNC;
                    end else begin
                        // The quiet cycle spent in RESYNC is the single
                        // no-grant cycle; arbitration resumes at its exit.
                        r_state <= c_ST_RUN;
                        if (w_found) begin
                            r_gnt <= c_ONE_HOT0 << w_win;
                            r_inc <= ~bus.op[w_win];
                            r_dec <= bus.op[w_win];
                            r_rr  <= w_rr_next;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.inc        = r_inc;
    assign bus.dec        = r_dec;
    assign bus.exp_cnt    = r_exp_cnt;
    assign bus.at_max     = w_proj_max;
    assign bus.at_min     = w_proj_min;
    assign bus.err        = r_err;
    assign bus.err_sticky = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_counter_inc_dec_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_inc_dec_arb
// Brief    : Self-checking bench for counter_inc_dec_arb with an external
//            up/down counter model, held-request requesters and a grant
//            scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_inc_dec_arb;

    localparam int NREQ = 4;
    localparam int CW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    counter_inc_dec_arb_if #(.NREQ(NREQ), .CW(CW)) bus ();

    counter_inc_dec_arb #(
        .NREQ (NREQ),
        .CW   (CW),
        .MAX  (255),
        .MIN  (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // External counter, with a one-shot load used to inject an upset
    logic [CW-1:0] cnt_model;
    logic          force_en  = 1'b0;
    logic [CW-1:0] force_val = '0;

    always @(posedge clk) begin
        if (rst)           cnt_model <= '0;
        else if (force_en) cnt_model <= force_val;
        else               cnt_model <= cnt_model + CW'(bus.inc) - CW'(bus.dec);
    end

    assign bus.cnt = cnt_model;

    // Requester model: n[i] operations outstanding, op fixed per requester
    int              n[NREQ];
    logic [NREQ-1:0] opv = '0;
    int              exp_q[$];   // expected winner order
    int              total = 0;
    int              bad   = 0;
    int              cyc   = 0;

    task automatic apply();
        logic [NREQ-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i] = (n[i] > 0);
        bus.req = v;
        bus.op  = opv;
    endtask

    // Advance to the next sampling point; a requester that sees its grant
    // counts the op done and drops req once it has none left.
    task automatic step();
        apply();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NREQ; i++) if (bus.gnt[i] && n[i] > 0) n[i]--;
        apply();
    endtask

    function automatic bit busy();
        bit b = (exp_q.size() != 0);
        for (int i = 0; i < NREQ; i++) if (n[i] > 0) b = 1'b1;
        return b;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) n[i] = 0;
        opv = '0;
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus.gnt !== 4'b0000 || bus.inc !== 1'b0 || bus.dec !== 1'b0) begin
            bad++;
            $display("FAIL reset_outs: gnt=%b inc=%b dec=%b, required 0000/0/0", bus.gnt, bus.inc, bus.dec);
        end
        total++;
        if (bus.exp_cnt !== 8'd0 || bus.err !== 1'b0 || bus.err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: exp_cnt=%0d err=%b sticky=%b, required 0/0/0", bus.exp_cnt, bus.err, bus.err_sticky);
        end
        total++;
        if (bus.at_min !== 1'b1 || bus.at_max !== 1'b0) begin
            bad++;
            $display("FAIL reset_limits: at_min=%b at_max=%b, required 1/0", bus.at_min, bus.at_max);
        end
    endtask

    task automatic test_single();
        int k;
        int want_cyc[$];
        do_reset();
        n[0] = 2;
        exp_q = '{0, 0};
        want_cyc = '{2, 4};
        for (int c = 0; c < 20 && busy(); c++) begin
            step();
            if (bus.gnt !== 4'b0000) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL single_gnt: gnt=%b, required none", bus.gnt);
                end else begin
                    k = exp_q.pop_front();
                    if (bus.gnt !== (4'b0001 << k) || bus.inc !== 1'b1 || cyc != want_cyc.pop_front()) begin
                        bad++;
                        $display("FAIL single_gnt: gnt=%b inc=%b cycle=%0d, required gnt[%0d] inc=1 at cycles 2,4", bus.gnt, bus.inc, cyc, k);
                    end
                end
            end
        end
        total++;
        if (busy()) begin bad++; $display("FAIL single_timeout: %0d grants still owed", exp_q.size()); end
        step();
        step();
        total++;
        if (cnt_model !== 8'd2 || bus.exp_cnt !== 8'd2 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL single_count: cnt=%0d exp_cnt=%0d err=%b, required 2/2/0", cnt_model, bus.exp_cnt, bus.err);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        do_reset();
        for (int i = 0; i < NREQ; i++) n[i] = 2;
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int c = 0; c < 30 && busy(); c++) begin
            step();
            total++;
            if (bus.inc && bus.dec) begin bad++; $display("FAIL b2b_incdec: inc=1 dec=1, required never both"); end
            if (bus.gnt !== 4'b0000) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_gnt: gnt=%b, required none", bus.gnt);
                end else begin
                    k = exp_q.pop_front();
                    if (bus.gnt !== (4'b0001 << k) || bus.inc !== 1'b1) begin
                        bad++;
                        $display("FAIL b2b_gnt: gnt=%b inc=%b, required gnt[%0d] inc=1", bus.gnt, bus.inc, k);
                    end
                end
            end
        end
        total++;
        if (busy()) begin bad++; $display("FAIL b2b_timeout: %0d grants still owed", exp_q.size()); end
        step();
        step();
        total++;
        if (cnt_model !== 8'd8 || bus.exp_cnt !== 8'd8) begin
            bad++;
            $display("FAIL b2b_count: cnt=%0d exp_cnt=%0d, required 8/8", cnt_model, bus.exp_cnt);
        end
    endtask

    task automatic test_max();
        int k;
        logic [NREQ-1:0] seen;
        do_reset();
        n[0] = 64; n[1] = 64; n[2] = 64; n[3] = 63;
        for (int r = 0; r < 63; r++) for (int i = 0; i < NREQ; i++) exp_q.push_back(i);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        for (int c = 0; c < 400 && busy(); c++) begin
            step();
            if (bus.gnt !== 4'b0000) begin
                total++;
                k = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
                if (k < 0 || bus.gnt !== (4'b0001 << k)) begin
                    bad++;
                    $display("FAIL max_fill_gnt: gnt=%b, required requester %0d", bus.gnt, k);
                end
            end
        end
        total++;
        if (busy()) begin bad++; $display("FAIL max_fill_timeout: %0d grants still owed", exp_q.size()); end
        step();
        step();
        total++;
        if (cnt_model !== 8'd255 || bus.exp_cnt !== 8'd255 || bus.at_max !== 1'b1) begin
            bad++;
            $display("FAIL max_reached: cnt=%0d exp_cnt=%0d at_max=%b, required 255/255/1", cnt_model, bus.exp_cnt, bus.at_max);
        end
        // Increment must stall at MAX
        n[2] = 1;
        seen = '0;
        for (int c = 0; c < 6; c++) begin
            step();
            seen = seen | bus.gnt;
        end
        total++;
        if (seen !== 4'b0000 || bus.at_max !== 1'b1) begin
            bad++;
            $display("FAIL max_stall: grants seen=%b at_max=%b, required 0000/1", seen, bus.at_max);
        end
        // A decrement frees room for the stalled increment
        opv[1] = 1'b1;
        n[1] = 1;
        exp_q = '{1, 2};
        for (int c = 0; c < 10 && busy(); c++) begin
            step();
            if (bus.gnt !== 4'b0000) begin
                total++;
                k = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
                if (k < 0 || bus.gnt !== (4'b0001 << k) || bus.dec !== (k == 1) || bus.inc !== (k == 2)) begin
                    bad++;
                    $display("FAIL max_release_gnt: gnt=%b inc=%b dec=%b, required requester %0d", bus.gnt, bus.inc, bus.dec, k);
                end
                if (k == 2) begin
                    total++;
                    if (cnt_model !== 8'd254) begin
                        bad++;
                        $display("FAIL max_release_cnt: cnt=%0d, required 254", cnt_model);
                    end
                end
            end
        end
        total++;
        if (busy()) begin bad++; $display("FAIL max_release_timeout: %0d grants still owed", exp_q.size()); end
        step();
        step();
        total++;
        if (cnt_model !== 8'd255) begin bad++; $display("FAIL max_final: cnt=%0d, required 255", cnt_model); end
    endtask

    task automatic test_min();
        int k;
        logic [NREQ-1:0] seen;
        do_reset();
        opv = 4'b0001;
        n[0] = 1;
        seen = '0;
        for (int c = 0; c < 5; c++) begin
            step();
            seen = seen | bus.gnt;
        end
        total++;
        if (seen !== 4'b0000 || bus.at_min !== 1'b1) begin
            bad++;
            $display("FAIL min_stall: grants seen=%b at_min=%b, required 0000/1", seen, bus.at_min);
        end
        n[3] = 1;
        exp_q = '{3, 0};
        for (int c = 0; c < 10 && busy(); c++) begin
            step();
            if (bus.gnt !== 4'b0000) begin
                total++;
                k = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
                if (k < 0 || bus.gnt !== (4'b0001 << k) || bus.inc !== (k == 3) || bus.dec !== (k == 0)) begin
                    bad++;
                    $display("FAIL min_gnt: gnt=%b inc=%b dec=%b, required requester %0d", bus.gnt, bus.inc, bus.dec, k);
                end
                if (k == 0) begin
                    total++;
                    if (cnt_model !== 8'd1) begin bad++; $display("FAIL min_mid_cnt: cnt=%0d, required 1", cnt_model); end
                end
            end
        end
        total++;
        if (busy()) begin bad++; $display("FAIL min_timeout: %0d grants still owed", exp_q.size()); end
        step();
        step();
        total++;
        if (cnt_model !== 8'd0 || bus.at_min !== 1'b1) begin
            bad++;
            $display("FAIL min_final: cnt=%0d at_min=%b, required 0/1", cnt_model, bus.at_min);
        end
    endtask

    task automatic test_mismatch();
        int k;
        bit got;
        opv = '0;
        n[0] = 3;
        exp_q = '{0, 0, 0};
        for (int c = 0; c < 20 && busy(); c++) begin
            step();
            if (bus.gnt !== 4'b0000 && exp_q.size() != 0) k = exp_q.pop_front();
        end
        step();
        step();
        total++;
        if (cnt_model !== 8'd3 || bus.exp_cnt !== 8'd3 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL mm_setup: cnt=%0d exp_cnt=%0d err=%b, required 3/3/0", cnt_model, bus.exp_cnt, bus.err);
        end
        // Upset the counter for one edge
        force_val = 8'h5A;
        force_en  = 1'b1;
        step();
        force_en  = 1'b0;
        n[1] = 1;
        total++;
        if (cnt_model !== 8'h5A || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL mm_inject: cnt=%h err=%b, required 5a/0", cnt_model, bus.err);
        end
        step();
        total++;
        if (bus.err !== 1'b1 || bus.err_sticky !== 1'b1 || bus.exp_cnt !== 8'h5A || bus.gnt !== 4'b0000) begin
            bad++;
            $display("FAIL mm_detect: err=%b sticky=%b exp_cnt=%h gnt=%b, required 1/1/5a/0000", bus.err, bus.err_sticky, bus.exp_cnt, bus.gnt);
        end
        got = 1'b0;
        for (int c = 0; c < 3 && !got; c++) begin
            step();
            if (c == 0) begin
                total++;
                if (bus.err !== 1'b0) begin bad++; $display("FAIL mm_pulse: err=%b one cycle later, required 0", bus.err); end
            end
            if (bus.gnt !== 4'b0000) begin
                got = 1'b1;
                total++;
                if (bus.gnt !== 4'b0010 || bus.inc !== 1'b1) begin
                    bad++;
                    $display("FAIL mm_resume: gnt=%b inc=%b, required 0010/1", bus.gnt, bus.inc);
                end
            end
        end
        total++;
        if (!got) begin bad++; $display("FAIL mm_resume_timeout: no grant after resync"); end
        step();
        step();
        total++;
        if (cnt_model !== 8'h5B || bus.exp_cnt !== 8'h5B || bus.err !== 1'b0 || bus.err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL mm_final: cnt=%h exp_cnt=%h err=%b sticky=%b, required 5b/5b/0/1", cnt_model, bus.exp_cnt, bus.err, bus.err_sticky);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        opv = '0;
        for (int i = 0; i < NREQ; i++) n[i] = 2;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            if (bus.inc === 1'b1) got = 1'b1;
        end
        total++;
        if (!got) begin bad++; $display("FAIL rstmid_setup: inc never rose"); end
        rst = 1'b1;
        step();
        total++;
        if (bus.gnt !== 4'b0000 || bus.inc !== 1'b0 || bus.dec !== 1'b0 || bus.exp_cnt !== 8'd0 ||
            bus.err_sticky !== 1'b0 || cnt_model !== 8'd0) begin
            bad++;
            $display("FAIL rstmid_clear: gnt=%b inc=%b dec=%b exp_cnt=%0d sticky=%b cnt=%0d, required all 0",
                     bus.gnt, bus.inc, bus.dec, bus.exp_cnt, bus.err_sticky, cnt_model);
        end
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) n[i] = 1;
        step();
        total++;
        if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL rstmid_sync: gnt=%b, required 0000", bus.gnt); end
        step();
        total++;
        if (bus.gnt !== 4'b0001 || bus.inc !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_first: gnt=%b inc=%b, required 0001/1", bus.gnt, bus.inc);
        end
    endtask

    initial begin
        bus.req = '0;
        bus.op  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_max();
        test_min();
        test_mismatch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/counter_inc_dec_arb.md
Name: counter_inc_dec_arb

Overview:
- Round-robin arbiter that shares one external 8-bit up/down counter (inputs inc/dec, output cnt, which updates one clock after inc/dec) between NREQ requesters.
- Each requester asks for one increment or one decrement. The arbiter grants at most one operation per cycle and drives the counter's inc/dec.
- Grants never push the count past MAX or below MIN.
- Keeps an expected-count shadow. Flags and resynchronises when the counter's cnt diverges from it, for example after an upset or forced value.

Parameters:
NREQ, 4, number of requesters (2..8)
CW, 8, counter width
MAX, 255, highest count the arbiter may grant an increment up to
MIN, 0, lowest count the arbiter may grant a decrement down to

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req  input  NREQ  per-requester request; held until granted
op  input  NREQ  per-requester operation, 0=increment 1=decrement; stable while req high
gnt  output  NREQ  one-hot grant pulse, one cycle
inc  output  1  to counter inc
dec  output  1  to counter dec
cnt  input  CW  counter value, reflects inc/dec of previous cycle
exp_cnt  output  CW  expected counter value (shadow)
at_max  output  1  projected count == MAX
at_min  output  1  projected count == MIN
err  output  1  one-cycle pulse on cnt/exp_cnt mismatch
err_sticky  output  1  set by err, cleared only by rst

Behaviour:
- Reset values: gnt=0, inc=0, dec=0, exp_cnt=0, err=0, err_sticky=0, rr pointer=0, state=SYNC. The external counter also resets to 0.
- States:
  - SYNC: first cycle after rst deasserts; no grants; go to RUN.
  - RUN: normal arbitration.
  - RESYNC: entered on mismatch; no grants for exactly one cycle; then back to RUN.
- Projected count: proj = exp_cnt + inc - dec, using the registered outputs of the current cycle. at_max = (proj==MAX), at_min = (proj==MIN); both are combinational from registers.
- Eligibility in RUN:
  - Requester i is eligible iff req[i] && ((op[i]==0 && proj!=MAX) || (op[i]==1 && proj!=MIN)).
  - A requester granted in the current cycle (gnt[i]=1) is ineligible this cycle, so a held req is not double-granted.
- Arbitration:
  - Search order is rr, rr+1, ... modulo NREQ; the first eligible requester k wins.
  - Registered at the next edge: gnt[k]=1, inc=~op[k], dec=op[k], rr=k+1 mod NREQ.
  - With no eligible requester: gnt=0, inc=dec=0, rr unchanged.
  - inc and dec are never both 1.
- Latency: req sampled in cycle t → gnt/inc/dec high in t+1 → cnt updated in t+2. Requesters drop req (or present the next op) in the cycle after seeing gnt.
- Shadow update each edge: exp_cnt <= exp_cnt + inc - dec (width CW). Wrap cannot occur because eligibility blocks it.
- Mismatch check, active in RUN and RESYNC:
  - If cnt != exp_cnt: err=1 next cycle, err_sticky=1.
  - exp_cnt <= cnt + inc - dec, adopting the observed value plus the in-flight op.
  - Go to RESYNC, with gnt/inc/dec forced 0 next cycle.
  - No check is performed in SYNC.
- Non-eligible requests are stalled, not dropped. A requester blocked at MAX/MIN waits until the count moves.
- Simultaneous inc and dec requests compete only via round-robin; there is no pairing or cancellation.
- rst mid-operation: all outputs return to reset values at the next edge. Any in-flight op is discarded; the counter is also reset.
- Implementation size is 150-250 lines.

Test Plan:
1. Reset, then req=4'b0001 op=0 held 3 cycles → gnt[0] pulses in cycles 2 and 4 (one grant per req-hold pair, never consecutive), inc pulses match, cnt=2, exp_cnt=2, err=0.
2. req=4'b1111, all op=0, held 8 grants → gnt order 0,1,2,3,0,1,2,3 one-hot; cnt=8; inc never coincides with dec.
3. Drive count to MAX=255 via increments, then req[2] op=0 held → no grant while proj=255, at_max=1. Then req[1] op=1 → dec granted, cnt=254, after which req[2] is granted and cnt=255.
4. From reset, req[0] op=1 (count 0=MIN) → no grant, at_min=1. Add req[3] op=0 → gnt[3], cnt=1, then gnt[0], cnt=0.
5. Force cnt to 8'h5A for one cycle while exp_cnt=3 and no op in flight → err pulses once, err_sticky=1, exp_cnt=8'h5A, one cycle of no grants, then arbitration resumes from 8'h5A.
6. Assert rst for one cycle while req=4'b1111 and inc=1 → next cycle gnt=0, inc=dec=0, exp_cnt=0, err_sticky=0. First grant goes to requester 0 two cycles after rst falls.
